// File: rtl/mux_n_pkg.sv
// Shared constants for the N-channel streaming selector.
// Mode encodings select between external-select and round-robin arbitration.
package mux_n_pkg;
   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;
   localparam int   DEF_N      = 4;
   localparam int   DEF_WIDTH  = 8;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping modulo N.
// Zero latency; no handshake of its own.
module rr_pick
   import mux_n_pkg::*;
#(
   parameter int N     = DEF_N,
   parameter int SEL_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [SEL_W-1:0] ptr,
   output logic             gnt_valid,
   output logic [SEL_W-1:0] gnt_idx
);
   logic [N-1:0]     rot;
   logic [SEL_W-1:0] off;

   // Rotate so ptr lands at bit 0, pick the lowest set bit, then rotate the index back.
   always_comb begin
      rot = '0;
      for (int i = 0; i < N; i++) begin
         rot[i] = req[SEL_W'((i + int'(ptr)) % N)];
      end
      gnt_valid = |rot;
      off = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) off = SEL_W'(i);
      end
      gnt_idx = SEL_W'((int'(off) + int'(ptr)) % N);
   end
endmodule

// File: rtl/mux_n_rr.sv
// N-channel registered stream mux, fixed or round-robin selection; one cycle input-to-output latency.
// Backpressure: out_ready low with out_valid high holds the output word and drops every in_ready.
module mux_n_rr
   import mux_n_pkg::*;
#(
   parameter int N     = DEF_N,
   parameter int WIDTH = DEF_WIDTH,
   parameter int SEL_W = $clog2(N)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               mode,
   input  logic [SEL_W-1:0]   sel,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_valid,
   output logic [N-1:0]       in_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic [SEL_W-1:0]   out_chan,
   output logic               out_valid,
   input  logic               out_ready
);
   logic [WIDTH-1:0] lane [N];
   logic [SEL_W-1:0] ptr;
   logic [SEL_W-1:0] rr_idx;
   logic [SEL_W-1:0] gnt_idx;
   logic             rr_vld;
   logic             fix_vld;
   logic             gnt_vld;
   logic             free;
   logic             take;

   rr_pick #(.N(N), .SEL_W(SEL_W)) u_pick (
      .req       (in_valid),
      .ptr       (ptr),
      .gnt_valid (rr_vld),
      .gnt_idx   (rr_idx)
   );

   always_comb begin
      for (int k = 0; k < N; k++) begin
         lane[k] = in_data[k*WIDTH +: WIDTH];
      end
   end

   // An out-of-range select must never grant, even when N is not a power of two.
   assign fix_vld = (int'(sel) < N) && in_valid[sel];
   assign gnt_vld = (mode == MODE_RR) ? rr_vld : fix_vld;
   assign gnt_idx = (mode == MODE_RR) ? rr_idx : sel;
   assign free    = !out_valid || out_ready;
   assign take    = free && gnt_vld && !rst;

   always_comb begin
      in_ready = '0;
      for (int k = 0; k < N; k++) begin
         in_ready[k] = take && (gnt_idx == SEL_W'(k));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
         ptr       <= '0;
      end else if (free) begin
         if (gnt_vld) begin
            out_valid <= 1'b1;
            out_data  <= lane[gnt_idx];
            out_chan  <= gnt_idx;
            // Tracked in fixed mode too, so round-robin resumes after the last channel served.
            ptr       <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: doc/mux_n_rr.md
# mux_n_rr

Parametrised N-channel, WIDTH-bit registered multiplexer with per-channel valid/ready handshakes and two selection modes: fixed (external select) and round-robin. It generalises the single-bit 2:1 combinational mux to a streaming selector. It sits between several producers and one consumer, with one output register stage.

## Interface
- `N`, default 4: number of input channels, minimum 2.
- `WIDTH`, default 8: data width per channel.
- `SEL_W`, default `$clog2(N)`: derived width of the channel index; not overridden.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `mode` input, 1 bit: 0 selects fixed mode; 1 selects round-robin mode.
- `sel` input, SEL_W bits: channel index used in fixed mode; ignored in round-robin mode.
- `in_data` input, N*WIDTH bits: channel k occupies bits [k*WIDTH +: WIDTH].
- `in_valid` input, N bits: per-channel valid.
- `in_ready` output, N bits: per-channel ready; combinational; at most one bit high.
- `out_data` output, WIDTH bits: registered selected data.
- `out_chan` output, SEL_W bits: registered index of the channel that sourced `out_data`.
- `out_valid` output, 1 bit: registered output valid.
- `out_ready` input, 1 bit: consumer ready.

## Operation
- `free = !out_valid || out_ready`: the output register can accept a word this cycle.
- Grant computation is combinational each cycle and reads the current `mode`:
  - Fixed mode: grant channel `sel` if `sel < N` and `in_valid[sel]`; otherwise no grant. A `sel >= N` never grants.
  - Round-robin mode: grant the first channel with `in_valid` high, searching from `ptr` upward, modulo N. No valid channel means no grant.
- `in_ready[g] = free && grant_exists && !rst` for the granted channel g. All other bits are 0.
- A transfer occurs when `in_valid[g] && in_ready[g]`. On a transfer:
  - `out_data <= in_data[g]`, `out_chan <= g`, `out_valid <= 1`.
  - `ptr <= (g == N-1) ? 0 : g+1`. The pointer updates in both modes, so switching to round-robin resumes after the last channel served.
- If `free` and there is no grant: `out_valid <= 0`. `out_data` and `out_chan` hold.
- If not `free` (`out_valid && !out_ready`): all registers hold and every `in_ready` bit is 0.
- Output stability: while `out_valid && !out_ready`, `out_data` and `out_chan` must not change.
- Fairness: in round-robin mode with all N channels continuously valid and `out_ready` high, the grants run 0,1,…,N-1,0,… Each channel is served exactly once per N transfers.
- `mode` or `sel` change mid-stream: the change takes effect on the next grant computation. A word already in the output register is unaffected.

## Timing
- Reset, one `clk` edge with `rst` high, produces: `out_valid=0`, `out_data=0`, `out_chan=0`, `ptr=0`. `in_ready` is all-zero while `rst` is high.
- Reset asserted mid-stream discards the held output word. No input transfer occurs in that cycle.
- Latency: a word accepted at edge t is visible on `out_data` with `out_valid=1` after edge t.
- Throughput: one word per cycle while `out_ready` stays high and a grant exists.
- Simultaneous events: when `out_valid && out_ready` and a grant exists in the same cycle, the old word is consumed and the new word is loaded on the same edge, with no bubble.
- Backpressure: `out_ready` low with `out_valid` high forces `in_ready=0` in the same cycle, because it enters combinationally through `free`.

## Structure
- Package `mux_n_pkg`:
  - Mode constants `MODE_FIXED=1'b0` and `MODE_RR=1'b1`.
  - Default parameter constants.
- Sub-module `rr_pick` (parameter N): inputs `req[N]` and `ptr[SEL_W]`; outputs `gnt_valid` and `gnt_idx`. It is purely combinational, implemented as a rotate / priority-encode / unrotate.
- `mux_n_rr` holds `ptr`, the output register, the mode-select logic and the ready decode.

## Test plan
- Reset: drive `rst=1` for 2 cycles with all inputs valid. Required: `in_ready=0000`, `out_valid=0`, `out_data=0`, `out_chan=0`. After release with `mode=1` and all valid, the first `out_chan=0`.
- Fixed mode: N=4, WIDTH=8, `mode=0`, `sel=2`, `in_data` lanes `{0x44,0x33,0x22,0x11}`, `in_valid=0100`. Required: `in_ready=0100`, and one cycle later `out_data=0x33`, `out_chan=2`. Then set `in_valid[2]=0`. Required: `out_valid=0` on the next edge.
- Round-robin fairness: `mode=1`, `in_valid=1111`, `out_ready=1` for 8 cycles. Required: `out_chan` sequence 0,1,2,3,0,1,2,3 with `out_valid` continuously high.
- Round-robin skip and wrap: `in_valid=1001`, `ptr=0`. Required: grants 0,3,0,3 (channels 1 and 2 skipped; wrap from 3 to 0).
- Backpressure: while `out_valid=1`, hold `out_ready=0` for 3 cycles. Required: `out_data` and `out_chan` are stable and `in_ready=0000`. Release: the next word loads on the same edge with no bubble.
- Mid-stream reset and bad select:
  - Assert `rst` while `out_valid=1`. Required: `out_valid=0` next edge.
  - Instantiate N=3 and drive `sel=3` in fixed mode. Required: `in_ready=000`, no transfer.
